// File: rtl/alu_issue_stage_if.sv
// ---------------------------------------------------------------------------
// alu_issue_stage_if
//   Handshake and data bundle between the upstream register-read stage, the
//   alu_issue_stage decoder/FIFO and the downstream ALU/EX stage.
//
//   Upstream side : in_valid, in_ready, in_instr, in_rs_data, in_rt_data
//   Downstream    : out_valid, out_ready, out_opcode, out_a, out_b, out_dest,
//                   out_wr_en, out_is_branch, out_illegal
//
//   slave  : the issue stage itself (consumes in_*, produces out_*)
//   master : the environment around it (feeds in_*, consumes out_*)
// ---------------------------------------------------------------------------
interface alu_issue_stage_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_rs_data;
  logic [31:0] in_rt_data;

  logic        out_valid;
  logic        out_ready;
  logic [2:0]  out_opcode;
  logic [31:0] out_a;
  logic [31:0] out_b;
  logic [4:0]  out_dest;
  logic        out_wr_en;
  logic        out_is_branch;
  logic        out_illegal;

  modport master (
    output in_valid, in_instr, in_rs_data, in_rt_data, out_ready,
    input  in_ready, out_valid, out_opcode, out_a, out_b, out_dest,
           out_wr_en, out_is_branch, out_illegal
  );

  modport slave (
    input  in_valid, in_instr, in_rs_data, in_rt_data, out_ready,
    output in_ready, out_valid, out_opcode, out_a, out_b, out_dest,
           out_wr_en, out_is_branch, out_illegal
  );
endinterface

// File: rtl/alu_issue_stage.sv
// ---------------------------------------------------------------------------
// alu_issue_stage
//   Decodes one MIPS instruction per cycle into the ALU's 3-bit opcode and
//   final A/B operands, then buffers the decoded entry in a 2-entry FIFO with
//   valid/ready handshakes on both sides.
//
//   Ports:
//     clk   - rising-edge clock
//     rst_n - asynchronous active-low reset (flushes the FIFO immediately)
//     bus   - alu_issue_stage_if.slave: instruction in, decoded entry out
//
//   in_ready comes straight from a flop so there is no combinational path
//   from out_ready back to in_ready. All out_* data reads 0 when out_valid=0.
// ---------------------------------------------------------------------------
module alu_issue_stage (
  input  logic               clk,
  input  logic               rst_n,
  alu_issue_stage_if.slave   bus
);

  localparam int DEPTH = 2;

  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_SLL  = 3'b001,
    OP_SUB  = 3'b010,
    OP_RSVD = 3'b011,
    OP_XOR  = 3'b100,
    OP_SRL  = 3'b101,
    OP_OR   = 3'b110,
    OP_AND  = 3'b111
  } alu_op_e;

  typedef struct packed {
    alu_op_e     opcode;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  dest;
    logic        wr_en;
    logic        is_branch;
    logic        illegal;
  } entry_t;

  localparam entry_t ILLEGAL_ENTRY = '{
    opcode: OP_RSVD, a: '0, b: '0, dest: '0,
    wr_en: 1'b0, is_branch: 1'b0, illegal: 1'b1
  };

  // -------------------------------------------------------------------------
  // Instruction fields
  // -------------------------------------------------------------------------
  logic [5:0]  w_op;
  logic [4:0]  w_rt;
  logic [4:0]  w_rd;
  logic [4:0]  w_shamt;
  logic [5:0]  w_funct;
  logic [31:0] w_se;
  logic [31:0] w_ze;

  assign w_op    = bus.in_instr[31:26];
  assign w_rt    = bus.in_instr[20:16];
  assign w_rd    = bus.in_instr[15:11];
  assign w_shamt = bus.in_instr[10:6];
  assign w_funct = bus.in_instr[5:0];
  assign w_se    = {{16{bus.in_instr[15]}}, bus.in_instr[15:0]};
  assign w_ze    = {16'h0000, bus.in_instr[15:0]};

  // -------------------------------------------------------------------------
  // Combinational decode
  // -------------------------------------------------------------------------
  entry_t w_dec;

  always_comb begin
    // NOTE: every field gets a value before the case, so no path through the
    // decode can leave a field unassigned and infer a latch.
    w_dec = ILLEGAL_ENTRY;
    case (w_op)
      6'b000000: begin
        // R-type: common fields first, shifts override the operands.
        w_dec           = '0;
        w_dec.dest      = w_rd;
        w_dec.wr_en     = 1'b1;
        w_dec.a         = bus.in_rs_data;
        w_dec.b         = bus.in_rt_data;
        case (w_funct)
          6'b100000, 6'b100001: w_dec.opcode = OP_ADD;
          6'b100010, 6'b100011: w_dec.opcode = OP_SUB;
          6'b100100:            w_dec.opcode = OP_AND;
          6'b100101:            w_dec.opcode = OP_OR;
          6'b100110:            w_dec.opcode = OP_XOR;
          6'b000000: begin
            w_dec.opcode = OP_SLL;
            w_dec.a      = bus.in_rt_data;
            w_dec.b      = {27'b0, w_shamt};
          end
          6'b000010: begin
            w_dec.opcode = OP_SRL;
            w_dec.a      = bus.in_rt_data;
            w_dec.b      = {27'b0, w_shamt};
          end
          default:              w_dec = ILLEGAL_ENTRY;
        endcase
      end
      6'b001000, 6'b001001, 6'b100011, 6'b101011: begin
        // addi/addiu/lw/sw all form rs + SE(imm); only sw skips write-back.
        w_dec        = '0;
        w_dec.opcode = OP_ADD;
        w_dec.a      = bus.in_rs_data;
        w_dec.b      = w_se;
        w_dec.dest   = w_rt;
        w_dec.wr_en  = (w_op != 6'b101011);
      end
      6'b001100, 6'b001101, 6'b001110: begin
        w_dec        = '0;
        w_dec.a      = bus.in_rs_data;
        w_dec.b      = w_ze;
        w_dec.dest   = w_rt;
        w_dec.wr_en  = 1'b1;
        case (w_op[1:0])
          2'b00:   w_dec.opcode = OP_AND;
          2'b01:   w_dec.opcode = OP_OR;
          default: w_dec.opcode = OP_XOR;
        endcase
      end
      6'b000100, 6'b000101: begin
        // beq/bne: subtract and let EX look at the zero flag.
        w_dec           = '0;
        w_dec.opcode    = OP_SUB;
        w_dec.a         = bus.in_rs_data;
        w_dec.b         = bus.in_rt_data;
        w_dec.dest      = w_rt;
        w_dec.is_branch = 1'b1;
      end
      default: w_dec = ILLEGAL_ENTRY;
    endcase
  end

  // -------------------------------------------------------------------------
  // 2-entry FIFO
  // -------------------------------------------------------------------------
  entry_t      r_mem [DEPTH];
  logic        r_wr_ptr;
  logic        r_rd_ptr;
  logic [1:0]  r_count;
  logic        r_in_ready;
  logic [1:0]  w_count_nxt;
  logic        w_push;
  logic        w_pop;
  logic        w_out_valid;

  assign w_out_valid = (r_count != 2'd0);
  assign w_push      = bus.in_valid & r_in_ready;
  assign w_pop       = w_out_valid & bus.out_ready;

  always_comb begin
    w_count_nxt = r_count;
    if (w_push && !w_pop)      w_count_nxt = r_count + 2'd1;
    else if (!w_push && w_pop) w_count_nxt = r_count - 2'd1;
  end

  // NOTE: the storage array has no reset; its contents are only visible
  // through the valid-qualified output mux, so resetting it would buy nothing.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= w_dec;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr   <= 1'b0;
      r_rd_ptr   <= 1'b0;
      r_count    <= 2'd0;
      r_in_ready <= 1'b1;
    end else begin
      // One-bit pointers wrap naturally from 1 back to 0.
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count    <= w_count_nxt;
      r_in_ready <= (w_count_nxt != 2'd2);
    end
  end

  // -------------------------------------------------------------------------
  // Outputs: head entry, forced to zero when empty
  // -------------------------------------------------------------------------
  entry_t w_head;

  assign w_head = w_out_valid ? r_mem[r_rd_ptr] : '0;

  assign bus.in_ready      = r_in_ready;
  assign bus.out_valid     = w_out_valid;
  assign bus.out_opcode    = w_head.opcode;
  assign bus.out_a         = w_head.a;
  assign bus.out_b         = w_head.b;
  assign bus.out_dest      = w_head.dest;
  assign bus.out_wr_en     = w_head.wr_en;
  assign bus.out_is_branch = w_head.is_branch;
  assign bus.out_illegal   = w_head.illegal;

endmodule
